// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames (8E1/8O1 when UART_TX_PARITY_EN is defined), LSB first,
// fed through a one-entry holding buffer so consecutive frames run back-to-back.
module uart_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int UARTBaud   = 115200,
  parameter int STOP_BITS  = 1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       uart_tx_done,
  output logic       uarttx
);

  localparam int          BIT_CYCLES = CLK_FREQ / UARTBaud;
  localparam logic [19:0] BIT_LAST   = 20'(BIT_CYCLES - 1);
  localparam logic        STOP_LAST  = (STOP_BITS == 2) ? 1'b1 : 1'b0;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  function automatic logic calc_parity(input logic [7:0] d);
    return (^d) ^ PARITY_ODD;
  endfunction
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } state_e;

  logic parity_unused_s;
  assign parity_unused_s = PARITY_ODD;
`endif

  state_e      state_r, state_nxt_s;
  logic [19:0] cnt_r;
  logic [2:0]  bit_idx_r;
  logic        stop_idx_r;
  logic [7:0]  shift_r;
  logic [7:0]  hold_data_r;
  logic        hold_valid_r;
  logic        hold_valid_nxt_s;
  logic        tx_ready_r;
  logic        tx_busy_r;
  logic        done_r;
  logic        uarttx_r;
`ifdef UART_TX_PARITY_EN
  logic        parity_r;
`endif

  logic bit_end_s, stop_end_s, load_s, accept_s;
  logic line_s, busy_s, done_s;

  assign bit_end_s  = (cnt_r == BIT_LAST);
  assign stop_end_s = bit_end_s && (stop_idx_r == STOP_LAST);
  // tx_ready is low while hold_valid_r is set, so load and accept never coincide
  assign load_s     = hold_valid_r && ((state_r == ST_IDLE) || ((state_r == ST_STOP) && stop_end_s));
  assign accept_s   = tx_valid && tx_ready_r;

  // Holding-buffer occupancy for the next cycle
  always_comb begin
    hold_valid_nxt_s = hold_valid_r;
    if (load_s) begin
      hold_valid_nxt_s = 1'b0;
    end else if (accept_s) begin
      hold_valid_nxt_s = 1'b1;
    end else begin
      hold_valid_nxt_s = hold_valid_r;
    end
  end

  // State register
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (hold_valid_r) state_nxt_s = ST_START;
        else              state_nxt_s = ST_IDLE;
      end
      ST_START: begin
        if (bit_end_s) state_nxt_s = ST_DATA;
        else           state_nxt_s = ST_START;
      end
      ST_DATA: begin
        if (bit_end_s && (bit_idx_r == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_nxt_s = ST_PARITY;
`else
          state_nxt_s = ST_STOP;
`endif
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end_s) state_nxt_s = ST_STOP;
        else           state_nxt_s = ST_PARITY;
      end
`endif
      ST_STOP: begin
        if (stop_end_s) state_nxt_s = hold_valid_r ? ST_START : ST_IDLE;
        else            state_nxt_s = ST_STOP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Bit timing, shifter and holding buffer
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cnt_r        <= 20'd0;
      bit_idx_r    <= 3'd0;
      stop_idx_r   <= 1'b0;
      shift_r      <= 8'd0;
      hold_data_r  <= 8'd0;
      hold_valid_r <= 1'b0;
      tx_ready_r   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_r     <= 1'b0;
`endif
    end else begin
      if ((state_r == ST_IDLE) || bit_end_s) cnt_r <= 20'd0;
      else                                   cnt_r <= cnt_r + 20'd1;

      if (state_r != ST_DATA) bit_idx_r <= 3'd0;
      else if (bit_end_s)     bit_idx_r <= bit_idx_r + 3'd1;
      else                    bit_idx_r <= bit_idx_r;

      if ((state_r != ST_STOP) || stop_end_s) stop_idx_r <= 1'b0;
      else if (bit_end_s)                     stop_idx_r <= 1'b1;
      else                                    stop_idx_r <= stop_idx_r;

      if (load_s)                                   shift_r <= hold_data_r;
      else if ((state_r == ST_DATA) && bit_end_s)   shift_r <= {1'b0, shift_r[7:1]};
      else                                          shift_r <= shift_r;

`ifdef UART_TX_PARITY_EN
      if (load_s) parity_r <= calc_parity(hold_data_r);
      else        parity_r <= parity_r;
`endif

      if (accept_s) hold_data_r <= tx_data;
      else          hold_data_r <= hold_data_r;

      hold_valid_r <= hold_valid_nxt_s;
      tx_ready_r   <= ~hold_valid_nxt_s;
    end
  end

  // Output decode from the current state
  always_comb begin
    line_s = 1'b1;
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        line_s = 1'b1;
        busy_s = 1'b0;
      end
      ST_START: begin
        line_s = 1'b0;
        busy_s = 1'b1;
      end
      ST_DATA: begin
        line_s = shift_r[0];
        busy_s = 1'b1;
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        line_s = parity_r;
        busy_s = 1'b1;
      end
`endif
      ST_STOP: begin
        line_s = 1'b1;
        busy_s = 1'b1;
        done_s = stop_end_s;
      end
      default: begin
        line_s = 1'b1;
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Output registers; the line trails the state register by one cycle
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      uarttx_r  <= 1'b1;
      tx_busy_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      uarttx_r  <= line_s;
      tx_busy_r <= busy_s;
      done_r    <= done_s;
    end
  end

  assign uarttx       = uarttx_r;
  assign tx_busy      = tx_busy_r;
  assign uart_tx_done = done_r;
  assign tx_ready     = tx_ready_r;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: two instances (1 stop/even, 2 stop/odd) checked every cycle
// against a frame-timing reference model; honours UART_TX_PARITY_EN.
module tb_uart_tx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int BC       = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] tx_valid = 2'b00;
  logic [7:0] tx_data [2];
  logic [1:0] tx_ready, tx_busy, uart_tx_done, uarttx;

  uart_tx #(.CLK_FREQ(CLK_FREQ), .UARTBaud(BAUD), .STOP_BITS(1), .PARITY_ODD(1'b0)) dut0 (
    .sys_clk(sys_clk), .rst(rst), .tx_valid(tx_valid[0]), .tx_data(tx_data[0]),
    .tx_ready(tx_ready[0]), .tx_busy(tx_busy[0]), .uart_tx_done(uart_tx_done[0]), .uarttx(uarttx[0]));

  uart_tx #(.CLK_FREQ(CLK_FREQ), .UARTBaud(BAUD), .STOP_BITS(2), .PARITY_ODD(1'b1)) dut1 (
    .sys_clk(sys_clk), .rst(rst), .tx_valid(tx_valid[1]), .tx_data(tx_data[1]),
    .tx_ready(tx_ready[1]), .tx_busy(tx_busy[1]), .uart_tx_done(uart_tx_done[1]), .uarttx(uarttx[1]));

  always #5 sys_clk = ~sys_clk;

  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  bit         hold_v [2];
  logic [7:0] hold_d [2];
  bit         cur_v [2];
  bit         prev_v [2];
  int         cur_t [2];
  int         prev_t [2];
  logic [7:0] cur_b [2];
  logic [7:0] prev_b [2];
  int         free_e [2];
  bit         acc_f [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic int stop_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int frame_len(input int i);
    return (1 + 8 + P + stop_of(i)) * BC;
  endfunction

  // Expected line level of a frame whose transfer edge is t, at cycle c; -1 when outside it
  function automatic int frame_bit(input int i, input int t, input logic [7:0] b, input int c);
    int off, k;
    off = c - (t + 1);
    if (off < 0 || off >= frame_len(i)) return -1;
    k = off / BC;
    if (k == 0) return 0;
    if (k <= 8) return int'(b[k-1]);
    if (P == 1 && k == 9) return int'(^b) ^ ((i == 0) ? 0 : 1);
    return 1;
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      acc_f[i] = 1'b0;
      if (rst) begin
        hold_v[i] = 1'b0;
        cur_v[i]  = 1'b0;
        prev_v[i] = 1'b0;
        free_e[i] = cyc;
      end else if (hold_v[i] && cyc >= free_e[i]) begin
        prev_v[i] = cur_v[i];
        prev_t[i] = cur_t[i];
        prev_b[i] = cur_b[i];
        cur_v[i]  = 1'b1;
        cur_t[i]  = cyc;
        cur_b[i]  = hold_d[i];
        free_e[i] = cyc + frame_len(i);
        hold_v[i] = 1'b0;
      end else if (tx_valid[i] && !hold_v[i]) begin
        hold_v[i] = 1'b1;
        hold_d[i] = tx_data[i];
        acc_f[i]  = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    int e0, e1, lv;
    bit busy, done;
    for (int i = 0; i < 2; i++) begin
      e0 = cur_v[i]  ? frame_bit(i, cur_t[i],  cur_b[i],  cyc) : -1;
      e1 = prev_v[i] ? frame_bit(i, prev_t[i], prev_b[i], cyc) : -1;
      lv = (e0 >= 0) ? e0 : ((e1 >= 0) ? e1 : 1);
      busy = (e0 >= 0) || (e1 >= 0);
      done = (cur_v[i]  && cyc == cur_t[i]  + frame_len(i)) ||
             (prev_v[i] && cyc == prev_t[i] + frame_len(i));
      chk($sformatf("uarttx%0d", i),  32'(uarttx[i]),       32'(lv));
      chk($sformatf("busy%0d", i),    32'(tx_busy[i]),      32'(busy));
      chk($sformatf("done%0d", i),    32'(uart_tx_done[i]), 32'(done));
      chk($sformatf("ready%0d", i),   32'(tx_ready[i]),     32'(!hold_v[i]));
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    cyc++;
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic offer(input logic [7:0] b);
    int budget;
    budget = 0;
    tx_valid = 2'b11;
    tx_data[0] = b;
    tx_data[1] = b;
    while (tx_valid != 2'b00 && budget < 3000) begin
      step();
      for (int i = 0; i < 2; i++) if (acc_f[i]) tx_valid[i] = 1'b0;
      budget++;
    end
    chk("offer_accepted", 32'(tx_valid), 32'd0);
    tx_valid = 2'b00;
  endtask

  initial begin
    tx_data[0] = 8'h00;
    tx_data[1] = 8'h00;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);

    offer(8'h55);
    idle(130);

    // second byte during DATA of the first, then changed data while the buffer is full
    offer(8'hA3);
    idle(40);
    offer(8'h0F);
    tx_valid = 2'b11;
    tx_data[0] = 8'hFF;
    tx_data[1] = 8'hFF;
    idle(20);
    tx_valid = 2'b00;
    idle(260);

    offer(8'h81);
    idle(40);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(5);
    offer(8'h3C);
    idle(140);

    offer(8'h00);
    idle(140);
    offer(8'h07);
    idle(140);

    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (tx_valid[i]) begin
          if (acc_f[i]) begin
            if ($urandom_range(0, 2) == 0) tx_data[i] = 8'($urandom);
            else tx_valid[i] = 1'b0;
          end else if ($urandom_range(0, 63) == 0) begin
            tx_valid[i] = 1'b0;
          end else if ($urandom_range(0, 3) == 0) begin
            tx_data[i] = 8'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          tx_valid[i] = 1'b1;
          tx_data[i] = 8'($urandom);
        end
      end
      rst = ($urandom_range(0, 799) == 0);
      step();
    end
    rst = 1'b0;
    tx_valid = 2'b00;
    idle(150);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
